// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the water-level FIFO slice.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

    // Levels need one extra bit so a completely full FIFO is representable.
    typedef logic [ADDR_W_DEF:0] level_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port; the array carries no reset so it maps onto block RAM.
    always_ff @(posedge sys_clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; output register resets to zero and holds between reads.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with pessimistic write-side and read-side water levels.
module sync_fifo_wl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned AF_LEVEL = 240,
    parameter int unsigned AE_LEVEL = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   wr_water_level,
    output logic [ADDR_W:0]   rd_water_level,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);

    typedef logic [ADDR_W:0] lvl_t;
    localparam lvl_t DEPTH_LVL = lvl_t'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    lvl_t              wr_lvl_q, wr_lvl_d;
    lvl_t              rd_lvl_q, rd_lvl_d;
    logic              wr_acc_q, rd_acc_q;
    logic              ovf_q, unf_q;
    logic              wr_acc, rd_acc;

    assign full         = (wr_lvl_q == DEPTH_LVL);
    assign empty        = (rd_lvl_q == '0);
    assign almost_full  = (wr_lvl_q >= lvl_t'(AF_LEVEL));
    assign almost_empty = (rd_lvl_q <= lvl_t'(AE_LEVEL));

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign wr_water_level = wr_lvl_q;
    assign rd_water_level = rd_lvl_q;
    assign overflow       = ovf_q;
    assign underflow      = unf_q;

    // Pointer advance and level update; each side sees the other side's
    // accept one cycle late, which keeps both levels on the safe side.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        wr_lvl_d = wr_lvl_q + lvl_t'(wr_acc)   - lvl_t'(rd_acc_q);
        rd_lvl_d = rd_lvl_q + lvl_t'(wr_acc_q) - lvl_t'(rd_acc);
    end

    // Pointer, level, delayed-accept and error-pulse registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_lvl_q <= '0;
            rd_lvl_q <= '0;
            wr_acc_q <= 1'b0;
            rd_acc_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_lvl_q <= wr_lvl_d;
            rd_lvl_q <= rd_lvl_d;
            wr_acc_q <= wr_acc;
            rd_acc_q <= rd_acc;
            ovf_q    <= wr_en & full;
            unf_q    <= rd_en & empty;
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Level arithmetic must never wrap in either direction.
    a_wr_lvl_max: assert property (@(posedge sys_clk) disable iff (!rst_n)
        wr_lvl_q <= DEPTH_LVL);
    a_lvl_order: assert property (@(posedge sys_clk) disable iff (!rst_n)
        rd_lvl_q <= wr_lvl_q);
    a_wr_lvl_under: assert property (@(posedge sys_clk) disable iff (!rst_n)
        !(rd_acc_q && !wr_acc && wr_lvl_q == '0));
    a_rd_lvl_over: assert property (@(posedge sys_clk) disable iff (!rst_n)
        !(wr_acc_q && !rd_acc && rd_lvl_q == DEPTH_LVL));

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Scoreboard bench for sync_fifo_wl against a queue-based reference model.
module tb_sync_fifo_wl;
    import fifo_pkg::*;

    localparam int DEPTH = 256;
    localparam int AF    = 240;
    localparam int AE    = 16;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b1;
    logic       wr_en   = 1'b0;
    logic       rd_en   = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    level_t     wr_water_level, rd_water_level;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: contents as a queue, expected read data as a scoreboard.
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    int         wlev      = 0;
    int         rlev      = 0;
    bit         rd_issued = 1'b0;
    bit         in_reset  = 1'b1;
    logic [7:0] last_rd   = '0;

    sync_fifo_wl #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .AF_LEVEL (240),
        .AE_LEVEL (16)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .wr_water_level (wr_water_level),
        .rd_water_level (rd_water_level),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model decides acceptance from the visible levels.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r);
        bit full_m, empty_m, acc_w, acc_r;
        @(negedge sys_clk);
        full_m  = (wlev == DEPTH);
        empty_m = (rlev == 0);
        acc_w   = w && !full_m;
        acc_r   = r && !empty_m;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        rd_issued = acc_r;
        if (acc_r) exp_q.push_back(model_q.pop_front());
        if (acc_w) model_q.push_back(d);
        @(posedge sys_clk);
        #1;
        // Writer still counts a slot freed this cycle; reader does not yet see a word written this cycle.
        wlev = model_q.size() + int'(acc_r);
        rlev = model_q.size() - int'(acc_w);
        chk("wr_level",     int'(wr_water_level), wlev);
        chk("rd_level",     int'(rd_water_level), rlev);
        chk("full",         int'(full),           int'(wlev == DEPTH));
        chk("empty",        int'(empty),          int'(rlev == 0));
        chk("almost_full",  int'(almost_full),    int'(wlev >= AF));
        chk("almost_empty", int'(almost_empty),   int'(rlev <= AE));
        chk("overflow",     int'(overflow),       int'(w && full_m));
        chk("underflow",    int'(underflow),      int'(r && empty_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (rlev > 0 || wlev > 0); i++) cycle(1'b0, 8'h00, rlev > 0);
        idle(2);
        chk("drained_wr_level", int'(wr_water_level), 0);
        chk("drained_queue", exp_q.size(), 0);
    endtask

    // Asynchronous reset pulled while both requests are active.
    task automatic do_reset();
        @(negedge sys_clk);
        wr_en     = 1'b1;
        rd_en     = 1'b1;
        wr_data   = 8'($urandom_range(0, 255));
        rd_issued = 1'b0;
        #2;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        #1;
        model_q.delete();
        exp_q.delete();
        wlev    = 0;
        rlev    = 0;
        last_rd = '0;
        chk("rst_rd_data",      int'(rd_data),        0);
        chk("rst_wr_level",     int'(wr_water_level), 0);
        chk("rst_rd_level",     int'(rd_water_level), 0);
        chk("rst_empty",        int'(empty),          1);
        chk("rst_almost_empty", int'(almost_empty),   1);
        chk("rst_full",         int'(full),           0);
        chk("rst_almost_full",  int'(almost_full),    0);
        chk("rst_overflow",     int'(overflow),       0);
        chk("rst_underflow",    int'(underflow),      0);
        @(negedge sys_clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: after every edge, compare rd_data with the scoreboard or its held value.
    initial begin
        bit         issued;
        logic [7:0] exp;
        forever begin
            @(posedge sys_clk);
            issued = rd_issued;
            #1;
            if (!in_reset) begin
                if (issued) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_scoreboard_nonempty", 0, 1);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("rd_data", int'(rd_data), int'(exp));
                        last_rd = exp;
                    end
                end else begin
                    chk("rd_data_hold", int'(rd_data), int'(last_rd));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int stream_cycles;
        bit w;
        bit r;

        do_reset();

        // Incrementing burst in, then out in order.
        for (int i = 1; i <= 128; i++) cycle(1'b1, 8'(i), 1'b0);
        idle(1);
        for (int i = 0; i < 128; i++) cycle(1'b0, 8'h00, 1'b1);
        idle(2);

        // Fill completely, one dropped write, then read everything back.
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        idle(1);
        for (int i = 0; i < 256; i++) cycle(1'b0, 8'h00, 1'b1);
        idle(2);

        // Reads while empty, including one with a simultaneous write.
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h5C, 1'b1);
        idle(1);
        drain();

        // Steady simultaneous traffic around level 10.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        idle(1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            chk("band_wr_level", int'(wr_water_level >= 9 && wr_water_level <= 11), 1);
            chk("band_rd_level", int'(rd_water_level >= 9 && rd_water_level <= 11), 1);
        end
        idle(1);
        chk("settled_wr_level", int'(wr_water_level), 10);
        chk("settled_rd_level", int'(rd_water_level), 10);
        drain();

        // Long incrementing stream across pointer wrap, level kept within 50..200.
        sent = 0;
        stream_cycles = 0;
        while (sent < 600 && stream_cycles < 5000) begin
            w = (wlev < 200) && ($urandom_range(0, 3) != 0);
            r = (rlev > 50) && ($urandom_range(0, 3) != 0);
            cycle(w, 8'(sent), r);
            if (w) sent++;
            stream_cycles++;
        end
        chk("stream_sent", sent, 600);
        drain();

        // Random mixed traffic, including runs into full and empty.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0));
        end
        drain();

        // Reset mid-burst at level 50; only post-reset data may come back.
        for (int i = 0; i < 50; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
        idle(2);
        chk("post_reset_empty", int'(empty), 1);
        chk("post_reset_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
